interrupt_controller: RTL

Arbitrates the 6502 interrupt sources (RESET, NMI, IRQ, BRK) and tells the control unit when to enter an interrupt sequence, which vector to fetch, and which B value to push.
- Consumes flag_interrupt_disable from the status register.
- Produces the set_interrupt_disable pulse that the status register uses to set I at the end of every interrupt/reset sequence.
- Sits between the external interrupt pins and the control unit.

---
 rtl/cpu_int_pkg.sv | 28 ++
 rtl/pin_synchronizer.sv | 40 ++++
 rtl/interrupt_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_int_pkg.sv
// -----------------------------------------------------------------------------
// cpu_int_pkg
// Shared types and constants for the 6502 interrupt controller.
//   int_kind_t  : which sequence the control unit is running (RESET/NMI/IRQ/BRK)
//   int_state_t : controller sequencing state
//   DEFAULT_*   : standard 6502 vector low-byte addresses
// -----------------------------------------------------------------------------
package cpu_int_pkg;

  typedef enum logic [1:0] {
    KIND_RESET = 2'd0,
    KIND_NMI   = 2'd1,
    KIND_IRQ   = 2'd2,
    KIND_BRK   = 2'd3
  } int_kind_t;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_IDLE    = 2'd1,
    S_SERVICE = 2'd2,
    S_LOCKED  = 2'd3
  } int_state_t;

  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] DEFAULT_NMI_VECTOR   = 16'hFFFA;
  localparam logic [15:0] DEFAULT_IRQ_VECTOR   = 16'hFFFE;

endpackage

// File: rtl/pin_synchronizer.sv
// -----------------------------------------------------------------------------
// pin_synchronizer
// Multi-flop synchronizer for an asynchronous active-low pin. All stages reset
// to 1 (pin inactive) so no spurious edge is seen when reset releases.
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   pin      : asynchronous input
//   pin_sync : synchronized copy, STAGES clocks of latency
// -----------------------------------------------------------------------------
module pin_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic pin_sync
);

  logic [STAGES-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= pin;
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge reset) begin
          if (reset) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign pin_sync = sync_reg[STAGES-1];

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Arbitrates RESET, NMI, IRQ and BRK for a 6502 core and tells the control unit
// which sequence it is running, which vector to fetch and which B bit to push.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   nmi_n, irq_n           : asynchronous interrupt pins (NMI falling edge, IRQ level)
//   flag_interrupt_disable : I flag from the status register
//   int_start, brk_start   : control unit begins hardware-interrupt / BRK sequence
//   vector_fetch           : first vector read this cycle, freezes kind/vector
//   vector_done            : PC loaded, sequence ends
//   int_request            : interrupt pending (valid at instruction boundary)
//   service_active         : a reset/interrupt/BRK sequence is in progress
//   service_kind           : kind of the current sequence
//   vector_addr            : low-byte vector address for the current sequence
//   push_b_flag            : B bit value for the pushed P byte
//   set_interrupt_disable  : one-cycle pulse to set I after the sequence
//   nmi_pending            : NMI edge latched but not yet serviced
// -----------------------------------------------------------------------------
module interrupt_controller
  import cpu_int_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [15:0] NMI_VECTOR   = DEFAULT_NMI_VECTOR,
  parameter logic [15:0] IRQ_VECTOR   = DEFAULT_IRQ_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        flag_interrupt_disable,
  input  logic        int_start,
  input  logic        brk_start,
  input  logic        vector_fetch,
  input  logic        vector_done,
  output logic        int_request,
  output logic        service_active,
  output logic [1:0]  service_kind,
  output logic [15:0] vector_addr,
  output logic        push_b_flag,
  output logic        set_interrupt_disable,
  output logic        nmi_pending
);

  int_state_t  state_reg, state_next;
  int_kind_t   kind_reg, kind_next;
  logic [15:0] vector_reg;
  logic        push_b_reg, push_b_next;
  logic        sid_reg, sid_next;
  logic        nmi_latch_reg, nmi_latch_next;
  logic        nmi_prev_reg;
  logic        nmi_sync, irq_sync;
  logic        nmi_edge, irq_active;

  pin_synchronizer #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk      (clk),
    .reset    (reset),
    .pin      (nmi_n),
    .pin_sync (nmi_sync)
  );

  pin_synchronizer #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .pin      (irq_n),
    .pin_sync (irq_sync)
  );

  function automatic logic [15:0] vector_of(input int_kind_t kind);
    case (kind)
      KIND_RESET: vector_of = RESET_VECTOR;
      KIND_NMI:   vector_of = NMI_VECTOR;
      default:    vector_of = IRQ_VECTOR;
    endcase
  endfunction

  assign nmi_edge   = nmi_prev_reg & ~nmi_sync;
  assign irq_active = ~irq_sync & ~flag_interrupt_disable;

  always_comb begin
    state_next     = state_reg;
    kind_next      = kind_reg;
    push_b_next    = push_b_reg;
    // New edges always latch; a pending NMI absorbs further edges.
    nmi_latch_next = nmi_latch_reg | nmi_edge;
    sid_next       = 1'b0;

    case (state_reg)
      S_RESET: begin
        if (vector_fetch) state_next = S_LOCKED;
      end
      S_IDLE: begin
        if (int_start) begin
          // int_start takes priority over a simultaneous brk_start; an
          // int_start with nothing pending is a protocol error and is dropped.
          if (nmi_latch_reg) begin
            kind_next      = KIND_NMI;
            nmi_latch_next = 1'b0;
            push_b_next    = 1'b0;
            state_next     = S_SERVICE;
          end else if (irq_active) begin
            kind_next   = KIND_IRQ;
            push_b_next = 1'b0;
            state_next  = S_SERVICE;
          end
        end else if (brk_start) begin
          kind_next   = KIND_BRK;
          push_b_next = 1'b1;
          state_next  = S_SERVICE;
        end
      end
      S_SERVICE: begin
        // NMI hijack: until the vector is frozen, a pending or arriving NMI
        // redirects an IRQ/BRK sequence to the NMI vector. B is left alone.
        if ((kind_reg == KIND_IRQ || kind_reg == KIND_BRK) &&
            (nmi_latch_reg | nmi_edge)) begin
          kind_next      = KIND_NMI;
          nmi_latch_next = 1'b0;
        end
        if (vector_fetch) state_next = S_LOCKED;
      end
      S_LOCKED: begin
        if (vector_done) begin
          sid_next    = 1'b1;
          push_b_next = 1'b0;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_RESET;
      kind_reg      <= KIND_RESET;
      vector_reg    <= RESET_VECTOR;
      push_b_reg    <= 1'b0;
      sid_reg       <= 1'b0;
      nmi_latch_reg <= 1'b0;
      nmi_prev_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      kind_reg      <= kind_next;
      // Decoded from the next kind so a hijack in the fetch cycle is captured.
      vector_reg    <= vector_of(kind_next);
      push_b_reg    <= push_b_next;
      sid_reg       <= sid_next;
      nmi_latch_reg <= nmi_latch_next;
      nmi_prev_reg  <= nmi_sync;
    end
  end

  assign int_request           = (state_reg == S_IDLE) & (nmi_latch_reg | irq_active);
  assign service_active        = (state_reg != S_IDLE);
  assign service_kind          = kind_reg;
  assign vector_addr           = vector_reg;
  assign push_b_flag           = push_b_reg;
  assign set_interrupt_disable = sid_reg;
  assign nmi_pending           = nmi_latch_reg;

endmodule
